// File: rtl/vga_layer_compositor.sv
// Per-pixel N-layer sprite compositor: colour-keyed priority select, frame-latched layer
// mask and overlay mode, highlight/blink overlap overlay and per-frame collision report.
module vga_layer_compositor #(
    parameter int unsigned        NUM_LAYERS   = 6,
    parameter int unsigned        COLOR_W      = 12,
    parameter logic [COLOR_W-1:0] BG_COLOR     = 12'h69C,
    parameter logic [COLOR_W-1:0] KEY_COLOR    = 12'hF0F,
    parameter int unsigned        HL_LAYER     = 0,
    parameter int unsigned        HAZ_LAYER    = 4,
    parameter logic [COLOR_W-1:0] HL_COLOR     = 12'hFFF,
    parameter int unsigned        BLINK_FRAMES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          bright_in,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]         layer_mask_in,
    input  logic [1:0]                    overlay_mode_in,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic                          bright_out,
    output logic                          hit_pulse,
    output logic                          blink_phase
);

    localparam int unsigned           CNT_W    = $clog2(BLINK_FRAMES) + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [NUM_LAYERS-1:0] HL_BIT   = NUM_LAYERS'(1) << HL_LAYER;
    localparam logic [NUM_LAYERS-1:0] HAZ_BIT  = NUM_LAYERS'(1) << HAZ_LAYER;

    typedef enum logic [1:0] {
        MODE_PRIO  = 2'd0,
        MODE_HL    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    // Frame-synchronous shadow state
    logic [NUM_LAYERS-1:0] mask_q, mask_d;
    mode_e                 mode_q, mode_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic                  blink_q, blink_d;
    logic                  hit_sticky_q, hit_sticky_d;
    logic                  hit_pulse_q, hit_pulse_d;

    // Stage 1 pipeline registers
    logic [COLOR_W-1:0]    s1_rgb_q, s1_rgb_d;
    logic                  s1_bright_q, s1_bright_d;
    logic                  s1_ovl_q, s1_ovl_d;
    logic                  s1_player_q, s1_player_d;
    logic                  s1_haz_q, s1_haz_d;
    mode_e                 s1_mode_q, s1_mode_d;

    // Stage 2 output registers
    logic [COLOR_W-1:0]    rgb_q, rgb_d;
    logic                  bright_q, bright_d;

    logic [NUM_LAYERS-1:0] qual_c;
    logic [COLOR_W-1:0]    prio_rgb_c;
    logic                  hit_c;

    // Qualify layers and pick the lowest-index qualified colour
    always_comb begin
        qual_c     = '0;
        prio_rgb_c = BG_COLOR;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            qual_c[i] = layer_en[i] & mask_q[i]
                      & (layer_rgb[i*COLOR_W +: COLOR_W] != KEY_COLOR);
            if (qual_c[i]) begin
                prio_rgb_c = layer_rgb[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_comb begin
        s1_rgb_d    = prio_rgb_c;
        s1_bright_d = bright_in;
        s1_player_d = |(qual_c & HL_BIT);
        s1_haz_d    = |(qual_c & HAZ_BIT);
        s1_ovl_d    = (|(qual_c & HL_BIT)) & (|(qual_c & ~HL_BIT));
        s1_mode_d   = mode_q;
    end

    assign hit_c = s1_bright_q & s1_player_q & s1_haz_q;

    // Shadow load, blink divider and collision sticky all advance on frame_start
    always_comb begin
        mask_d       = mask_q;
        mode_d       = mode_q;
        frame_cnt_d  = frame_cnt_q;
        blink_d      = blink_q;
        hit_sticky_d = hit_sticky_q | hit_c;
        hit_pulse_d  = 1'b0;
        if (frame_start) begin
            mask_d       = layer_mask_in;
            mode_d       = mode_e'(overlay_mode_in);
            hit_pulse_d  = hit_sticky_q;
            hit_sticky_d = hit_c;
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rgb_d    = '0;
        bright_d = s1_bright_q;
        if (s1_bright_q) begin
            rgb_d = s1_rgb_q;
            case (s1_mode_q)
                MODE_HL:    if (s1_ovl_q)           rgb_d = HL_COLOR;
                MODE_BLINK: if (s1_ovl_q & blink_q) rgb_d = HL_COLOR;
                default:    rgb_d = s1_rgb_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q       <= '1;
            mode_q       <= MODE_PRIO;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b0;
            hit_sticky_q <= 1'b0;
            hit_pulse_q  <= 1'b0;
            s1_rgb_q     <= '0;
            s1_bright_q  <= 1'b0;
            s1_ovl_q     <= 1'b0;
            s1_player_q  <= 1'b0;
            s1_haz_q     <= 1'b0;
            s1_mode_q    <= MODE_PRIO;
            rgb_q        <= '0;
            bright_q     <= 1'b0;
        end else begin
            mask_q       <= mask_d;
            mode_q       <= mode_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            hit_sticky_q <= hit_sticky_d;
            hit_pulse_q  <= hit_pulse_d;
            s1_rgb_q     <= s1_rgb_d;
            s1_bright_q  <= s1_bright_d;
            s1_ovl_q     <= s1_ovl_d;
            s1_player_q  <= s1_player_d;
            s1_haz_q     <= s1_haz_d;
            s1_mode_q    <= s1_mode_d;
            rgb_q        <= rgb_d;
            bright_q     <= bright_d;
        end
    end

    assign rgb_out     = rgb_q;
    assign bright_out  = bright_q;
    assign hit_pulse   = hit_pulse_q;
    assign blink_phase = blink_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor: priority, key, mask shadowing, overlay modes,
// blink divider, reset behaviour and collision reporting.
module tb_vga_layer_compositor;

    localparam int unsigned NL = 6;
    localparam int unsigned CW = 12;

    logic              clk;
    logic              reset;
    logic              frame_start;
    logic              bright_in;
    logic [NL-1:0]     layer_en;
    logic [NL*CW-1:0]  layer_rgb;
    logic [NL-1:0]     layer_mask_in;
    logic [1:0]        overlay_mode_in;
    logic [CW-1:0]     rgb_out;
    logic              bright_out;
    logic              hit_pulse;
    logic              blink_phase;

    logic [CW-1:0]     col [NL];
    int                vectors     = 0;
    int                miscompares = 0;

    vga_layer_compositor #(.BLINK_FRAMES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .bright_in       (bright_in),
        .layer_en        (layer_en),
        .layer_rgb       (layer_rgb),
        .layer_mask_in   (layer_mask_in),
        .overlay_mode_in (overlay_mode_in),
        .rgb_out         (rgb_out),
        .bright_out      (bright_out),
        .hit_pulse       (hit_pulse),
        .blink_phase     (blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pack_rgb;
        for (int i = 0; i < int'(NL); i++) layer_rgb[i*CW +: CW] = col[i];
    endtask

    task automatic frame_pulse;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        bright_in = 1'b1;
        layer_en  = '1;
        reset     = 1'b0;
        tick();
        tick();
        if (rgb_out !== 12'h000) begin miscompares++; $display("FAIL reset_rgb got %h want 000", rgb_out); end
        vectors++;
        if (bright_out !== 1'b0) begin miscompares++; $display("FAIL reset_bright got %b want 0", bright_out); end
        vectors++;
        if (hit_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_hit got %b want 0", hit_pulse); end
        vectors++;
        if (blink_phase !== 1'b0) begin miscompares++; $display("FAIL reset_blink got %b want 0", blink_phase); end
        vectors++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_priority;
        logic [NL-1:0] en_v  [4] = '{6'b010100, 6'b100000, 6'b000001, 6'b111111};
        logic [CW-1:0] exp_v [4] = '{12'h345,   12'h678,   12'h123,   12'h123};
        bright_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            layer_en = en_v[k];
            tick();
            tick();
            if (rgb_out !== exp_v[k]) begin miscompares++; $display("FAIL prio_%0d rgb got %h want %h", k, rgb_out, exp_v[k]); end
            vectors++;
            if (bright_out !== 1'b1) begin miscompares++; $display("FAIL prio_bright_%0d got %b want 1", k, bright_out); end
            vectors++;
        end
    endtask

    task automatic test_background;
        bright_in = 1'b1;
        layer_en  = '0;
        tick();
        tick();
        if (rgb_out !== 12'h69C) begin miscompares++; $display("FAIL bg_color got %h want 69c", rgb_out); end
        vectors++;
        bright_in = 1'b0;
        layer_en  = 6'b010100;
        tick();
        tick();
        if (rgb_out !== 12'h000) begin miscompares++; $display("FAIL blank_rgb got %h want 000", rgb_out); end
        vectors++;
        if (bright_out !== 1'b0) begin miscompares++; $display("FAIL blank_bright got %b want 0", bright_out); end
        vectors++;
        bright_in = 1'b1;
    endtask

    task automatic test_colorkey;
        col[2] = 12'hF0F;
        pack_rgb();
        layer_en = 6'b001100;
        tick();
        tick();
        if (rgb_out !== 12'h456) begin miscompares++; $display("FAIL key_fallthrough got %h want 456", rgb_out); end
        vectors++;
        layer_en = 6'b000100;
        tick();
        tick();
        if (rgb_out !== 12'h69C) begin miscompares++; $display("FAIL key_only got %h want 69c", rgb_out); end
        vectors++;
        col[2] = 12'h345;
        pack_rgb();
    endtask

    task automatic test_back_to_back;
        logic [NL-1:0] en_v  [6] = '{6'b010100, 6'b000000, 6'b100000, 6'b011000, 6'b111111, 6'b000001};
        logic          br_v  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [CW-1:0] exp_v [6] = '{12'h345, 12'h69C, 12'h678, 12'h456, 12'h000, 12'h123};
        for (int j = 0; j <= 6; j++) begin
            if (j < 6) begin
                layer_en  = en_v[j];
                bright_in = br_v[j];
            end
            tick();
            if (j >= 1) begin
                if (rgb_out !== exp_v[j-1]) begin miscompares++; $display("FAIL b2b_rgb_%0d got %h want %h", j-1, rgb_out, exp_v[j-1]); end
                vectors++;
                if (bright_out !== br_v[j-1]) begin miscompares++; $display("FAIL b2b_bright_%0d got %b want %b", j-1, bright_out, br_v[j-1]); end
                vectors++;
            end
        end
        bright_in = 1'b1;
    endtask

    task automatic test_mask;
        do_reset();
        layer_en = 6'b001100;
        tick();
        tick();
        if (rgb_out !== 12'h345) begin miscompares++; $display("FAIL mask_before got %h want 345", rgb_out); end
        vectors++;
        layer_mask_in = 6'b111011;
        tick();
        tick();
        if (rgb_out !== 12'h345) begin miscompares++; $display("FAIL mask_midframe got %h want 345", rgb_out); end
        vectors++;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        if (rgb_out !== 12'h345) begin miscompares++; $display("FAIL mask_inflight got %h want 345", rgb_out); end
        vectors++;
        tick();
        if (rgb_out !== 12'h456) begin miscompares++; $display("FAIL mask_applied got %h want 456", rgb_out); end
        vectors++;
        layer_mask_in = '1;
    endtask

    task automatic test_overlay_modes;
        do_reset();
        layer_en        = 6'b000011;
        overlay_mode_in = 2'd1;
        frame_pulse();
        tick();
        tick();
        if (rgb_out !== 12'hFFF) begin miscompares++; $display("FAIL hl_overlap got %h want fff", rgb_out); end
        vectors++;
        layer_en = 6'b000001;
        tick();
        tick();
        if (rgb_out !== 12'h123) begin miscompares++; $display("FAIL hl_player_only got %h want 123", rgb_out); end
        vectors++;
        layer_en = 6'b010010;
        tick();
        tick();
        if (rgb_out !== 12'h234) begin miscompares++; $display("FAIL hl_no_player got %h want 234", rgb_out); end
        vectors++;
        layer_en        = 6'b000011;
        overlay_mode_in = 2'd3;
        frame_pulse();
        tick();
        tick();
        if (rgb_out !== 12'h123) begin miscompares++; $display("FAIL mode3_prio got %h want 123", rgb_out); end
        vectors++;
        overlay_mode_in = 2'd1;
        tick();
        tick();
        if (rgb_out !== 12'h123) begin miscompares++; $display("FAIL mode_midframe got %h want 123", rgb_out); end
        vectors++;
        overlay_mode_in = 2'd0;
    endtask

    task automatic test_blink;
        logic          ph_v [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [CW-1:0] exp_c;
        do_reset();
        layer_en        = 6'b000011;
        overlay_mode_in = 2'd2;
        for (int k = 0; k < 6; k++) begin
            frame_pulse();
            tick();
            tick();
            exp_c = ph_v[k] ? 12'hFFF : 12'h123;
            if (blink_phase !== ph_v[k]) begin miscompares++; $display("FAIL blink_phase_%0d got %b want %b", k, blink_phase, ph_v[k]); end
            vectors++;
            if (rgb_out !== exp_c) begin miscompares++; $display("FAIL blink_rgb_%0d got %h want %h", k, rgb_out, exp_c); end
            vectors++;
        end
    endtask

    task automatic test_reset_midframe;
        #2;
        reset = 1'b0;
        #2;
        if (blink_phase !== 1'b0) begin miscompares++; $display("FAIL rst_mid_blink got %b want 0", blink_phase); end
        vectors++;
        if (rgb_out !== 12'h000) begin miscompares++; $display("FAIL rst_mid_rgb got %h want 000", rgb_out); end
        vectors++;
        tick();
        reset = 1'b1;
        tick();
        tick();
        if (rgb_out !== 12'h123) begin miscompares++; $display("FAIL rst_mid_mode got %h want 123", rgb_out); end
        vectors++;
        frame_pulse();
        if (blink_phase !== 1'b0) begin miscompares++; $display("FAIL rst_first_frame got %b want 0", blink_phase); end
        vectors++;
        frame_pulse();
        if (blink_phase !== 1'b1) begin miscompares++; $display("FAIL rst_second_frame got %b want 1", blink_phase); end
        vectors++;
        overlay_mode_in = 2'd0;
    endtask

    task automatic test_collision;
        do_reset();
        layer_en  = '0;
        bright_in = 1'b1;
        frame_pulse();
        tick();
        layer_en = 6'b010001;
        tick();
        layer_en = '0;
        tick();
        tick();
        frame_pulse();
        if (hit_pulse !== 1'b1) begin miscompares++; $display("FAIL hit_report got %b want 1", hit_pulse); end
        vectors++;
        tick();
        if (hit_pulse !== 1'b0) begin miscompares++; $display("FAIL hit_one_cycle got %b want 0", hit_pulse); end
        vectors++;
        tick();
        frame_pulse();
        if (hit_pulse !== 1'b0) begin miscompares++; $display("FAIL hit_clean_frame got %b want 0", hit_pulse); end
        vectors++;
        // hit term lands in the frame_start cycle itself
        layer_en = 6'b010001;
        tick();
        layer_en = '0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        if (hit_pulse !== 1'b0) begin miscompares++; $display("FAIL hit_coincide_now got %b want 0", hit_pulse); end
        vectors++;
        tick();
        tick();
        frame_pulse();
        if (hit_pulse !== 1'b1) begin miscompares++; $display("FAIL hit_coincide_next got %b want 1", hit_pulse); end
        vectors++;
        bright_in = 1'b0;
        layer_en  = 6'b010001;
        tick();
        bright_in = 1'b1;
        layer_en  = '0;
        tick();
        tick();
        frame_pulse();
        if (hit_pulse !== 1'b0) begin miscompares++; $display("FAIL hit_blanked got %b want 0", hit_pulse); end
        vectors++;
        layer_mask_in = 6'b101111;
        frame_pulse();
        layer_en = 6'b010001;
        tick();
        layer_en = '0;
        tick();
        tick();
        layer_mask_in = '1;
        frame_pulse();
        if (hit_pulse !== 1'b0) begin miscompares++; $display("FAIL hit_masked got %b want 0", hit_pulse); end
        vectors++;
        col[4] = 12'hF0F;
        pack_rgb();
        layer_en = 6'b010001;
        tick();
        layer_en = '0;
        tick();
        tick();
        frame_pulse();
        if (hit_pulse !== 1'b0) begin miscompares++; $display("FAIL hit_keyed got %b want 0", hit_pulse); end
        vectors++;
        col[4] = 12'h567;
        pack_rgb();
    endtask

    initial begin
        col = '{12'h123, 12'h234, 12'h345, 12'h456, 12'h567, 12'h678};
        reset           = 1'b0;
        frame_start     = 1'b0;
        bright_in       = 1'b0;
        layer_en        = '0;
        layer_rgb       = '0;
        layer_mask_in   = '1;
        overlay_mode_in = 2'd0;
        pack_rgb();
        test_reset();
        test_priority();
        test_background();
        test_colorkey();
        test_back_to_back();
        test_mask();
        test_overlay_modes();
        test_blink();
        test_reset_midframe();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
